demux16_router: RTL
===================

Name: demux16_router

Overview:
- Sequential 16-bit demultiplexer for the Hack datapath: the distributing counterpart of the 16-bit select-one-of-two word path.
- Accepts one input word stream with a valid/ready handshake and steers each word to output channel A (in_sel=0) or B (in_sel=1).
- Each output channel has its own small FIFO, so a stalled consumer does not block the other channel until its own FIFO fills.
- Sits between a single word producer (CPU/ALU output) and two word consumers.

Parameters:
DEPTH, 2, entries per output FIFO; power of 2, >= 2
CNT_W, 16, width of per-channel delivered-word counters

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
in_data  input  16  input word
in_sel  input  1  destination: 0 -> A, 1 -> B; qualified by in_valid
in_valid  input  1  input word valid
in_ready  output  1  router can accept the word toward the channel chosen by in_sel
a_data  output  16  head word of FIFO A
a_valid  output  1  FIFO A non-empty
a_ready  input  1  consumer A accepts a_data
b_data  output  16  head word of FIFO B
b_valid  output  1  FIFO B non-empty
b_ready  input  1  consumer B accepts b_data
a_count  output  CNT_W  words delivered on A (a_valid & a_ready)
b_count  output  CNT_W  words delivered on B
a_level  output  log2(DEPTH)+1  current occupancy of FIFO A
b_level  output  log2(DEPTH)+1  current occupancy of FIFO B

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - Both FIFOs are emptied; read/write pointers, levels and counts go to 0.
  - a_valid=b_valid=0; a_data=b_data=16'h0000.
  - Reset mid-operation discards all buffered words. No output handshake completes on the reset edge.
- in_ready is combinational: in_sel ? !full_B : !full_A. It depends on in_sel; in_valid must not depend on in_ready.
- Push: in_valid & in_ready at an edge writes in_data into the FIFO selected by in_sel. The other FIFO is untouched.
- Pop: x_valid & x_ready at an edge removes the head of FIFO x and increments x_count.
- Latency: a word pushed at edge N is visible as x_valid=1 / x_data after edge N, provided the FIFO was empty. There is no same-cycle input-to-output path.
- Ordering: words on each channel leave in acceptance order. There is no ordering relation between A and B.
- x_data holds the head entry whenever x_valid=1 and is stable until popped. When empty, x_data holds the last popped value; consumers ignore it.
- Simultaneous push and pop on the same FIFO:
  - Not full: the level is unchanged and both operations take effect.
  - Full (without the optional feature): in_ready=0, so no push occurs; the pop proceeds and the FIFO is no longer full next cycle.
- Simultaneous pop on A and B in the same cycle is fully independent.
- Levels: x_level counts 0..DEPTH; full when x_level==DEPTH, empty when x_level==0.
- Pointers wrap modulo DEPTH.
- Counters wrap modulo 2^CNT_W with no saturation and no flag.
- in_sel is ignored when in_valid=0.

Optional Feature:
DEMUX16_ROUTER_FULL_PASS_EN
- Defined:
  - in_ready for a channel is !full_x | x_ready.
  - A push to a full FIFO is accepted in the same cycle as its pop. The level stays DEPTH, and the new word enters at the tail behind the remaining entries.
  - This adds a combinational x_ready -> in_ready path.
- Undefined: in_ready = !full_x as specified above, with no path from x_ready to in_ready.

Test Plan:
- Reset, then hold a_ready=b_ready=1 and push 16'h1234 with in_sel=0 -> next cycle a_valid=1, a_data=16'h1234, b_valid=0; after the pop, a_count=1 and b_count=0.
- Alternating pushes 16'h0001 (A), 16'h0002 (B), 16'h0003 (A), 16'h0004 (B) with both readies=1 -> A delivers 1 then 3, B delivers 2 then 4; a_count=b_count=2.
- Backpressure:
  - Stimulus: a_ready=0; push three words to A with DEPTH=2.
  - Required: after two pushes, a_level=2 and in_ready=0 while in_sel=0; in_ready=1 when in_sel=1.
  - Required: a push of 16'hBEEF to B completes with b_valid=1 the next cycle.
- Full with pop:
  - Stimulus: FIFO A full with a_ready=1 and in_valid=1, in_sel=0.
  - Required without the macro: no push that cycle, a_level goes 2 -> 1.
  - Required with DEMUX16_ROUTER_FULL_PASS_EN: push accepted, a_level stays 2.
- Mid-operation reset: with a_level=2 and b_level=1, drive rst_n=0 for one edge -> a_valid=b_valid=0, levels=0, counts=0, a_data=b_data=0; subsequent push 16'h00FF to B is delivered alone.
- Counter wrap: with CNT_W=4, deliver 17 words on B -> b_count=1 and a_count=0.

Source files
------------

// File: rtl/demux16_router.sv
// demux16_router: steers a 16-bit word stream into two independent output FIFOs (A / B)
// Ports:
//   clk, rst_n                  clock and synchronous active-low reset
//   in_data, in_sel, in_valid   input word, destination (0=A, 1=B), valid
//   in_ready                    the channel chosen by in_sel can take a word
//   a_data, a_valid, a_ready    channel A head word and handshake
//   b_data, b_valid, b_ready    channel B head word and handshake
//   a_count, b_count            delivered-word counters, wrap modulo 2^CNT_W
//   a_level, b_level            FIFO occupancy 0..DEPTH
// Optional: define DEMUX16_ROUTER_FULL_PASS_EN to let a full FIFO accept a push
// in the same cycle its consumer pops.

module demux16_router_fifo #(
   parameter int DEPTH = 2,
   parameter int CNT_W = 16,
   parameter int LW    = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [15:0]      wdata,
   input  logic             ready,
   output logic [15:0]      data,
   output logic             valid,
   output logic             full,
   output logic [LW-1:0]    level,
   output logic [CNT_W-1:0] count
);
   localparam int PW = $clog2(DEPTH);
   logic [15:0]   mem [DEPTH];
   logic [PW-1:0] wr, rd;
   logic [15:0]   last;
   logic          pop;
   assign valid = level != '0;
   assign full  = level == LW'(DEPTH);
   assign pop   = valid & ready;
   // an empty FIFO keeps presenting the word it last delivered
   assign data  = valid ? mem[rd] : last;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr    <= '0;
         rd    <= '0;
         last  <= '0;
         level <= '0;
         count <= '0;
      end else begin
         // when full and popping, wr == rd: the freed slot takes the new tail word
         if (push) begin
            mem[wr] <= wdata;
            wr      <= wr + 1'b1;
         end
         if (pop) begin
            last  <= mem[rd];
            rd    <= rd + 1'b1;
            count <= count + 1'b1;
         end
         level <= level + LW'(push) - LW'(pop);
      end
   end
endmodule

module demux16_router #(
   parameter int DEPTH = 2,
   parameter int CNT_W = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [15:0]                in_data,
   input  logic                       in_sel,
   input  logic                       in_valid,
   output logic                       in_ready,
   output logic [15:0]                a_data,
   output logic                       a_valid,
   input  logic                       a_ready,
   output logic [15:0]                b_data,
   output logic                       b_valid,
   input  logic                       b_ready,
   output logic [CNT_W-1:0]           a_count,
   output logic [CNT_W-1:0]           b_count,
   output logic [$clog2(DEPTH):0]     a_level,
   output logic [$clog2(DEPTH):0]     b_level
);
   logic a_full, b_full, a_acc, b_acc;
`ifdef DEMUX16_ROUTER_FULL_PASS_EN
   assign a_acc = !a_full | a_ready;
   assign b_acc = !b_full | b_ready;
`else
   assign a_acc = !a_full;
   assign b_acc = !b_full;
`endif
   assign in_ready = in_sel ? b_acc : a_acc;
   demux16_router_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_a (
      .clk(clk), .rst_n(rst_n), .push(in_valid & a_acc & !in_sel), .wdata(in_data),
      .ready(a_ready), .data(a_data), .valid(a_valid), .full(a_full),
      .level(a_level), .count(a_count));
   demux16_router_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_b (
      .clk(clk), .rst_n(rst_n), .push(in_valid & b_acc & in_sel), .wdata(in_data),
      .ready(b_ready), .data(b_data), .valid(b_valid), .full(b_full),
      .level(b_level), .count(b_count));
endmodule
